alu_rs: RTL

ALU_RS -- requirements
Module: alu_rs

---
 rtl/alu_rs_pkg.sv | 8 +
 rtl/alu_rs_pick.sv | 16 +
 rtl/alu_rs.sv | 119 +++++++++++
 3 files changed

// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared widths and entry-state encoding for the ALU reservation station
package alu_rs_pkg;
   localparam int ALU_RS_WIDTH = 3;
   localparam int TAG_WIDTH    = 4;
   localparam int DATA_WIDTH   = 32;
   localparam int ALU_OP_WIDTH = 5;
   typedef enum logic [1:0] {FREE, WAIT, ISSUED} ent_state_t;
endpackage

// File: rtl/alu_rs_pick.sv
// alu_rs_pick: lowest-index priority encoder
module alu_rs_pick #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] req,
   output logic         any,
   output logic [W-1:0] idx
);
   always_comb begin
      any = |req;
      idx = '0;
      for (int i = N - 1; i >= 0; i--)
         if (req[i]) idx = W'(i);
   end
endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station with CDB wakeup, dispatch bypass and in-order-by-index issue
module alu_rs
   import alu_rs_pkg::*;
#(
   parameter int aluRSWidth = ALU_RS_WIDTH,
   parameter int tagWidth   = TAG_WIDTH,
   parameter int dataWidth  = DATA_WIDTH,
   parameter int aluOpWidth = ALU_OP_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  disValid,
   input  logic [aluOpWidth-1:0] disOp,
   input  logic [dataWidth-1:0]  disVal1,
   input  logic [dataWidth-1:0]  disVal2,
   input  logic [tagWidth-1:0]   disTag1,
   input  logic [tagWidth-1:0]   disTag2,
   input  logic                  disRdy1,
   input  logic                  disRdy2,
   input  logic [tagWidth-1:0]   disDestTag,
   output logic                  rsFull,
   input  logic                  cdbValid,
   input  logic [tagWidth-1:0]   cdbTag,
   input  logic [dataWidth-1:0]  cdbData,
   input  logic                  aluFinish,
   input  logic [aluRSWidth-1:0] aluRSNumIn,
   output logic                  aluValid,
   output logic [aluOpWidth-1:0] aluOp,
   output logic [dataWidth-1:0]  aluA,
   output logic [dataWidth-1:0]  aluB,
   output logic [tagWidth-1:0]   aluDestTag,
   output logic [aluRSWidth-1:0] aluRSNum
);
   localparam int N = 2 ** aluRSWidth;
   ent_state_t                st   [N];
   logic [aluOpWidth-1:0]     op   [N];
   logic [dataWidth-1:0]      val1 [N];
   logic [dataWidth-1:0]      val2 [N];
   logic [tagWidth-1:0]       tag1 [N];
   logic [tagWidth-1:0]       tag2 [N];
   logic [tagWidth-1:0]       dest [N];
   logic [N-1:0]              rdy1, rdy2, free_vec, ready_vec;
   logic                      free_any, rdy_any;
   logic [aluRSWidth-1:0]     free_idx, rdy_idx;
   logic                      d_rdy1, d_rdy2;
   logic [dataWidth-1:0]      d_val1, d_val2;
   always_comb begin
      for (int i = 0; i < N; i++) begin
         free_vec[i]  = st[i] == FREE;
         ready_vec[i] = st[i] == WAIT && rdy1[i] && rdy2[i];
      end
   end
   alu_rs_pick #(.N(N), .W(aluRSWidth)) u_free (.req(free_vec),  .any(free_any), .idx(free_idx));
   alu_rs_pick #(.N(N), .W(aluRSWidth)) u_rdy  (.req(ready_vec), .any(rdy_any),  .idx(rdy_idx));
   assign rsFull = ~free_any;
   // an operand whose producer broadcasts in the dispatch cycle is captured directly
   assign d_rdy1 = disRdy1 | (cdbValid && cdbTag == disTag1);
   assign d_rdy2 = disRdy2 | (cdbValid && cdbTag == disTag2);
   assign d_val1 = disRdy1 ? disVal1 : cdbData;
   assign d_val2 = disRdy2 ? disVal2 : cdbData;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            st[i]   <= FREE;
            op[i]   <= '0;
            val1[i] <= '0;
            val2[i] <= '0;
            tag1[i] <= '0;
            tag2[i] <= '0;
            dest[i] <= '0;
            rdy1[i] <= 1'b0;
            rdy2[i] <= 1'b0;
         end
         aluValid   <= 1'b0;
         aluOp      <= '0;
         aluA       <= '0;
         aluB       <= '0;
         aluDestTag <= '0;
         aluRSNum   <= '0;
      end else if (flush) begin
         for (int i = 0; i < N; i++) st[i] <= FREE;
         aluValid <= 1'b0;
      end else begin
         // wakeup, dispatch, issue and finish each touch entries in a distinct state
         for (int i = 0; i < N; i++) begin
            if (st[i] == WAIT && !rdy1[i] && cdbValid && cdbTag == tag1[i]) begin
               val1[i] <= cdbData;
               rdy1[i] <= 1'b1;
            end
            if (st[i] == WAIT && !rdy2[i] && cdbValid && cdbTag == tag2[i]) begin
               val2[i] <= cdbData;
               rdy2[i] <= 1'b1;
            end
         end
         if (disValid && free_any) begin
            st[free_idx]   <= WAIT;
            op[free_idx]   <= disOp;
            val1[free_idx] <= d_val1;
            val2[free_idx] <= d_val2;
            tag1[free_idx] <= disTag1;
            tag2[free_idx] <= disTag2;
            rdy1[free_idx] <= d_rdy1;
            rdy2[free_idx] <= d_rdy2;
            dest[free_idx] <= disDestTag;
         end
         aluValid <= rdy_any;
         if (rdy_any) begin
            st[rdy_idx] <= ISSUED;
            aluOp       <= op[rdy_idx];
            aluA        <= val1[rdy_idx];
            aluB        <= val2[rdy_idx];
            aluDestTag  <= dest[rdy_idx];
            aluRSNum    <= rdy_idx;
         end
         if (aluFinish && st[aluRSNumIn] == ISSUED) st[aluRSNumIn] <= FREE;
      end
   end
endmodule
